// File: rtl/ramdisk_block_buffer.sv
// ramdisk_block_buffer
//   Buffers one 256-word block between a host and the ramdisk. In IDLE the host
//   fills or drains a 256x16 circular buffer. A start command moves one whole
//   block to or from the ramdisk. A watchdog aborts a transfer that stalls.
//
// Ports
//   fifo_clk, reset_n           sole clock, async active-low reset
//   start_read/start_write      one-cycle host command pulses
//   start_block[31:0]           block number, latched when a start is accepted
//   busy, done, error           busy level; done/error are one-cycle pulses
//   host_wdata/wvalid/wready    host fill port (IDLE only)
//   host_rdata/rvalid/rready    host drain port (IDLE only, rdata is buf[head])
//   command_ready               ramdisk ready for a new command
//   read_cmd/write_cmd          held command level for the active transfer
//   block_address[31:0]         block of the current transfer
//   write_data/write_data_enable  buffer -> ramdisk, data registered after enable
//   read_data/read_data_enable    ramdisk -> buffer
//
// state    | meaning
// IDLE     | host owns the buffer, waiting for a start
// WAIT_RDY | start accepted, waiting for command_ready to issue the command
// XFER     | command held, moving words until 256 or watchdog expiry
// DROP     | command released, waiting for command_ready before done
module ramdisk_block_buffer #(
  parameter int unsigned WATCHDOG = 65535
) (
  input  logic        fifo_clk,
  input  logic        reset_n,
  input  logic        start_read,
  input  logic        start_write,
  input  logic [31:0] start_block,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [15:0] host_wdata,
  input  logic        host_wvalid,
  output logic        host_wready,
  output logic [15:0] host_rdata,
  output logic        host_rvalid,
  input  logic        host_rready,
  input  logic        command_ready,
  output logic        read_cmd,
  output logic        write_cmd,
  output logic [31:0] block_address,
  output logic [15:0] write_data,
  input  logic        write_data_enable,
  input  logic [15:0] read_data,
  input  logic        read_data_enable
);

  // Watchdog is a down-counter loaded with WATCHDOG-1, so it only needs to hold that value.
  localparam int unsigned WD_W = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_RDY, XFER, DROP} state_t;

  state_t            state, state_nxt;
  logic [15:0]       mem [256];
  logic [7:0]        head, tail;
  logic [8:0]        count, words;
  logic              mode_write;
  logic [WD_W-1:0]   wd_cnt;

  logic start_any, accept, start_err, push, pop, wr_take, rd_take;
  logic finish, abort, to_xfer, to_idle;

  assign start_any   = start_read | start_write;
  assign busy        = (state != IDLE);
  assign host_wready = (state == IDLE) && (count != 9'd256);
  assign host_rvalid = (state == IDLE) && (count != 9'd0);
  assign host_rdata  = mem[head];

  always_ff @(posedge fifo_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    start_err = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    wr_take   = 1'b0;
    rd_take   = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    to_xfer   = 1'b0;
    to_idle   = 1'b0;
    case (state)
      IDLE: begin
        push = host_wvalid && host_wready;
        pop  = host_rvalid && host_rready;
        // A write needs a full block to send; a read needs room for a full block.
        if (start_write && !start_read && count == 9'd256)     accept = 1'b1;
        else if (start_read && !start_write && count == 9'd0)  accept = 1'b1;
        else if (start_any)                                    start_err = 1'b1;
        if (accept) state_nxt = WAIT_RDY;
      end
      WAIT_RDY: begin
        start_err = start_any;
        if (command_ready) begin
          to_xfer   = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        start_err = start_any;
        wr_take   = mode_write  && write_data_enable && (words != 9'd256);
        rd_take   = !mode_write && read_data_enable  && (words != 9'd256);
        // Completing the block on the last watchdog cycle counts as success.
        finish    = (wr_take || rd_take) && (words == 9'd255);
        abort     = !finish && (wd_cnt == '0);
        if (finish || abort) state_nxt = DROP;
      end
      DROP: begin
        start_err = start_any;
        if (command_ready) begin
          to_idle   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fifo_clk or negedge reset_n) begin
    if (!reset_n) begin
      head          <= 8'd0;
      tail          <= 8'd0;
      count         <= 9'd0;
      words         <= 9'd0;
      wd_cnt        <= '0;
      mode_write    <= 1'b0;
      block_address <= 32'd0;
      read_cmd      <= 1'b0;
      write_cmd     <= 1'b0;
      write_data    <= 16'd0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      done  <= to_idle;
      error <= start_err || abort;
      if (accept) begin
        mode_write    <= start_write;
        block_address <= start_block;
      end
      if (to_xfer) begin
        read_cmd  <= !mode_write;
        write_cmd <= mode_write;
        words     <= 9'd0;
        wd_cnt    <= WD_W'(WATCHDOG - 1);
      end
      if (finish || abort) begin
        read_cmd  <= 1'b0;
        write_cmd <= 1'b0;
      end
      if (state == XFER && !finish && !abort) wd_cnt <= wd_cnt - 1'b1;
      if (wr_take) write_data <= mem[head];
      if (wr_take || rd_take) words <= words + 9'd1;
      if (pop || wr_take)  head <= head + 8'd1;
      if (push || rd_take) tail <= tail + 8'd1;
      if ((push || rd_take) && !(pop || wr_take))      count <= count + 9'd1;
      else if (!(push || rd_take) && (pop || wr_take)) count <= count - 9'd1;
    end
  end

  // Storage is not reset; contents are meaningless once the pointers clear.
  always_ff @(posedge fifo_clk) begin
    if (push)         mem[tail] <= host_wdata;
    else if (rd_take) mem[tail] <= read_data;
  end

endmodule
